// File: rtl/sat_div_16bit.sv
// sat_div_16bit: signed 16-bit restoring divider, 16 CALC cycles, saturating on overflow and divide-by-zero.
// Define DIV_REMAINDER_EN to add the signed REM output.
module sat_div_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] QUOT,
`ifdef DIV_REMAINDER_EN
    output logic [15:0] REM,
`endif
    output logic        busy,
    output logic        done,
    output logic        dbz
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic [15:0] r_dvd, r_rem;
    logic [16:0] r_bmag;
    logic        r_sq;
`ifdef DIV_REMAINDER_EN
    logic        r_sa;
`endif
    logic [15:0] w_amag, w_bmag, w_rem_n, w_quo_n, w_quot;
    logic [16:0] w_sh, w_diff;
    logic        w_ge, w_bz;
    assign w_amag  = A[15] ? -A : A;
    assign w_bmag  = B[15] ? -B : B;
    assign w_bz    = B == 16'd0;
    // 17-bit trial subtraction: bit 16 is the borrow, so 16'h8000 stays unsigned 32768
    assign w_sh    = {r_rem, r_dvd[15]};
    assign w_diff  = w_sh - r_bmag;
    assign w_ge    = ~w_diff[16];
    assign w_rem_n = w_ge ? w_diff[15:0] : w_sh[15:0];
    assign w_quo_n = {r_dvd[14:0], w_ge};
    assign w_quot  = r_sq ? -w_quo_n : (w_quo_n[15] ? 16'h7FFF : w_quo_n);
    assign busy    = r_state != IDLE;
    assign done    = r_state == DONE;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? (w_bz ? DONE : CALC) : IDLE;
            CALC:    w_next = (r_cnt == 4'd15) ? DONE : CALC;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 4'd0;
            r_dvd  <= 16'd0;
            r_rem  <= 16'd0;
            r_bmag <= 17'd0;
            r_sq   <= 1'b0;
            QUOT   <= 16'd0;
            dbz    <= 1'b0;
`ifdef DIV_REMAINDER_EN
            r_sa   <= 1'b0;
            REM    <= 16'd0;
`endif
        end else if (r_state == IDLE && start) begin
            r_cnt  <= 4'd0;
            r_dvd  <= w_amag;
            r_rem  <= 16'd0;
            r_bmag <= {1'b0, w_bmag};
            r_sq   <= A[15] ^ B[15];
            dbz    <= w_bz;
`ifdef DIV_REMAINDER_EN
            r_sa   <= A[15];
`endif
            if (w_bz) begin
                QUOT <= A[15] ? 16'h8000 : 16'h7FFF;
`ifdef DIV_REMAINDER_EN
                REM  <= A;
`endif
            end
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt + 4'd1;
            r_dvd <= w_quo_n;
            r_rem <= w_rem_n;
            if (r_cnt == 4'd15) begin
                QUOT <= w_quot;
`ifdef DIV_REMAINDER_EN
                REM  <= r_sa ? -w_rem_n : w_rem_n;
`endif
            end
        end
    end
endmodule

// File: tb/tb_sat_div_16bit.sv
// tb_sat_div_16bit: vector table, corner sequences and 1000 random back-to-back ops against a scoreboard.
module tb_sat_div_16bit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] A = 16'd0, B = 16'd0;
    logic [15:0] QUOT;
    logic        busy, done, dbz;
`ifdef DIV_REMAINDER_EN
    logic [15:0] REM;
`endif
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a, b, q, r;
        logic        z;
    } vec_t;
    vec_t sb[$];
    vec_t tbl[12];

    sat_div_16bit dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .QUOT(QUOT),
`ifdef DIV_REMAINDER_EN
        .REM(REM),
`endif
        .busy(busy), .done(done), .dbz(dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
        vec_t v;
        int ia, ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        v.a = a;
        v.b = b;
        v.z = 1'b0;
        if (b == 16'd0) begin
            v.q = a[15] ? 16'h8000 : 16'h7FFF;
            v.r = a;
            v.z = 1'b1;
        end else if (a == 16'h8000 && b == 16'hFFFF) begin
            v.q = 16'h7FFF;
            v.r = 16'd0;
        end else begin
            v.q = 16'(ia / ib);
            v.r = 16'(ia % ib);
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk($sformatf("quot %h/%h", e.a, e.b), 32'(QUOT), 32'(e.q));
                chk($sformatf("dbz %h/%h", e.a, e.b), 32'(dbz), 32'(e.z));
`ifdef DIV_REMAINDER_EN
                chk($sformatf("rem %h/%h", e.a, e.b), 32'(REM), 32'(e.r));
`endif
            end
        end
    end

    // Called at a negedge in an IDLE cycle; returns at the negedge of the following IDLE cycle.
    task automatic do_op(input vec_t e, input int poke_at);
        int lat;
        A = e.a;
        B = e.b;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == 1) chk("busy_in_calc", 32'(busy), 32'd1);
            if (lat == poke_at) begin
                A = 16'd1;
                B = 16'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk($sformatf("latency %h/%h", e.a, e.b), 32'(lat), (e.b == 16'd0) ? 32'd0 : 32'd16);
        @(negedge clk);
        chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int nd;
        vec_t v;
        tbl[0]  = '{16'd100,  16'd7,     16'd14,    16'd2,     1'b0};
        tbl[1]  = '{16'hFF9C, 16'd7,     16'hFFF2,  16'hFFFE,  1'b0};
        tbl[2]  = '{16'h8000, 16'hFFFF,  16'h7FFF,  16'h0000,  1'b0};
        tbl[3]  = '{16'h1234, 16'h0000,  16'h7FFF,  16'h1234,  1'b1};
        tbl[4]  = '{16'hF000, 16'h0000,  16'h8000,  16'hF000,  1'b1};
        tbl[5]  = '{16'h7FFF, 16'h0001,  16'h7FFF,  16'h0000,  1'b0};
        tbl[6]  = '{16'h8000, 16'h0001,  16'h8000,  16'h0000,  1'b0};
        tbl[7]  = '{16'h7FFF, 16'hFFFF,  16'h8001,  16'h0000,  1'b0};
        tbl[8]  = '{16'h8000, 16'h8000,  16'h0001,  16'h0000,  1'b0};
        tbl[9]  = '{16'h7FFF, 16'h8000,  16'h0000,  16'h7FFF,  1'b0};
        tbl[10] = '{16'hFFFF, 16'h7FFF,  16'h0000,  16'hFFFF,  1'b0};
        tbl[11] = '{16'd100,  16'hFFF9,  16'hFFF2,  16'h0002,  1'b0};

        #3 rst = 1'b1;
        #1;
        chk("reset_state", {13'd0, busy, done, dbz, QUOT}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) do_op(tbl[i], -1);

        // start pulsed during CALC must not disturb the running op or restart
        do_op(tbl[0], 4);

        // reset mid-CALC aborts with no done pulse
        A = 16'd100;
        B = 16'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2;
        chk("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_quot", 32'(QUOT), 32'd0);
`ifdef DIV_REMAINDER_EN
        chk("rst_rem", 32'(REM), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_abort", 32'(nd), 32'd0);

        do_op(tbl[1], -1);

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] r[2];
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 9))
                    0: r[k] = 16'h7FFF;
                    1: r[k] = 16'h8000;
                    2: r[k] = 16'h0001;
                    3: r[k] = 16'hFFFF;
                    4: r[k] = (k == 1 && $urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 255));
                    default: r[k] = 16'($urandom);
                endcase
            end
            v = model(r[0], r[1]);
            do_op(v, -1);
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
